id: RTL and testbench

ID -- requirements
Module: id

---
 rtl/id_if.sv | 53 +++++
 rtl/id.sv | 152 +++++++++++++++
 tb/tb_id.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/id_if.sv
// ---------------------------------------------------------------------------
// id_if -- bundle of every non-clock signal of the decode stage.
//
// Signal groups:
//   fetch     : inst_valid_i, inst_i -> decoder ; inst_ready_o <- decoder
//   control   : hold_i (downstream freeze)
//   writeback : wb_we_i, wb_waddr_i, wb_wdata_i (execute result into regfile)
//   issue     : inst_o, op1_o, op2_o, reg_waddr_o, illegal_o (registered)
//   debug     : dbg_raddr_i -> dbg_rdata_o (combinational regfile peek)
//
// Modports:
//   slave  : the decoder itself (module id)
//   master : whatever drives fetch/writeback and consumes the issue outputs
// ---------------------------------------------------------------------------
interface id_if;
  // fetch handshake
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        inst_ready_o;
  // downstream freeze
  logic        hold_i;
  // writeback port
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  // issue outputs
  logic [31:0] inst_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [4:0]  reg_waddr_o;
  logic        illegal_o;
  // debug peek
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;

  modport slave (
    input  inst_valid_i, inst_i, hold_i,
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  dbg_raddr_i,
    output inst_ready_o,
    output inst_o, op1_o, op2_o, reg_waddr_o, illegal_o,
    output dbg_rdata_o
  );

  modport master (
    output inst_valid_i, inst_i, hold_i,
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output dbg_raddr_i,
    input  inst_ready_o,
    input  inst_o, op1_o, op2_o, reg_waddr_o, illegal_o,
    input  dbg_rdata_o
  );
endinterface

// File: rtl/id.sv
// ---------------------------------------------------------------------------
// id -- single-stage RV32 instruction decode with integrated register file.
//
// Accepts one instruction per cycle from fetch (ready = ~hold), reads rs1
// from a 32x32 register file with writeback bypass, and registers the
// instruction, rs1 operand, sign-extended I-immediate and destination
// register toward execute. Only OP-IMM is supported; any other opcode is
// replaced by the bubble instruction and flagged for one cycle.
//
// Ports:
//   clk  : single clock, rising-edge state updates
//   rst  : synchronous active-high reset
//   bus  : id_if.slave (fetch, hold, writeback, issue outputs, debug peek)
//
// Parameters:
//   NOP_INST   : bubble instruction issued when nothing valid is decoded
//   CLEAR_REGS : 1 -> reset clears x1..x31, 0 -> reset leaves regfile alone
// ---------------------------------------------------------------------------
module id #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter bit          CLEAR_REGS = 1'b1
) (
  input  logic clk,
  input  logic rst,
  id_if.slave  bus
);

  localparam int          DATA_W     = 32;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  // I-type immediate, sign-extended to the datapath width.
  function automatic logic signed [DATA_W-1:0] sext_imm12(input logic [31:0] ins);
    logic signed [11:0] imm12;
    imm12 = signed'(ins[31:20]);
    return DATA_W'(imm12);
  endfunction

  // Register file read with x0 hard-wired to zero.
  logic [DATA_W-1:0] r_regs [32];

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] addr,
                                               input logic [DATA_W-1:0] data);
    return (addr == 5'd0) ? '0 : data;
  endfunction

  // -------------------------------------------------------------------------
  // Decode (combinational, stage p0)
  // -------------------------------------------------------------------------
  logic [6:0]               w_opcode_p0;
  logic [4:0]               w_rd_p0;
  logic [4:0]               w_rs1_p0;
  logic signed [DATA_W-1:0] w_imm_p0;
  logic                     w_accept_p0;
  logic                     w_op_imm_p0;
  logic                     w_wb_en;
  logic                     w_wb_hit_p0;
  logic signed [DATA_W-1:0] w_op1_p0;

  assign w_opcode_p0 = bus.inst_i[6:0];
  assign w_rd_p0     = bus.inst_i[11:7];
  assign w_rs1_p0    = bus.inst_i[19:15];
  assign w_imm_p0    = sext_imm12(bus.inst_i);

  assign bus.inst_ready_o = ~bus.hold_i;
  assign w_accept_p0      = bus.inst_valid_i & ~bus.hold_i;
  assign w_op_imm_p0      = (w_opcode_p0 == OPC_OP_IMM);

  // A write to x0 is never a real write, so it can neither update the file
  // nor be forwarded.
  assign w_wb_en     = bus.wb_we_i && (bus.wb_waddr_i != 5'd0);
  assign w_wb_hit_p0 = w_wb_en && (bus.wb_waddr_i == w_rs1_p0);

  // Same-cycle writeback to rs1 is forwarded so the issued operand is never
  // the stale pre-write value.
  assign w_op1_p0 = w_wb_hit_p0 ? signed'(bus.wb_wdata_i)
                                : signed'(rf_read(w_rs1_p0, r_regs[w_rs1_p0]));

  // Debug peek reads the array directly: no forwarding.
  assign bus.dbg_rdata_o = rf_read(bus.dbg_raddr_i, r_regs[bus.dbg_raddr_i]);

  // -------------------------------------------------------------------------
  // Register file write port (independent of hold)
  // -------------------------------------------------------------------------
  generate
    if (CLEAR_REGS) begin : g_rf_clear
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
          end
        end else if (w_wb_en) begin
          r_regs[bus.wb_waddr_i] <= bus.wb_wdata_i;
        end
      end
    end else begin : g_rf_keep
      always_ff @(posedge clk) begin
        if (w_wb_en) begin
          r_regs[bus.wb_waddr_i] <= bus.wb_wdata_i;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Issue register (stage p1)
  // -------------------------------------------------------------------------
  logic [31:0]              r_inst_p1;
  logic signed [DATA_W-1:0] r_op1_p1;
  logic signed [DATA_W-1:0] r_op2_p1;
  logic [4:0]               r_rd_p1;
  logic                     r_illegal_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_p1    <= NOP_INST;
      r_op1_p1     <= '0;
      r_op2_p1     <= '0;
      r_rd_p1      <= '0;
      r_illegal_p1 <= 1'b0;
    end else if (bus.hold_i) begin
      // Frozen: operand captured at issue is deliberately not refreshed by
      // writebacks that land during the hold. The illegal flag is a pulse.
      r_illegal_p1 <= 1'b0;
    end else if (w_accept_p0 && w_op_imm_p0) begin
      r_inst_p1    <= bus.inst_i;
      r_op1_p1     <= w_op1_p0;
      r_op2_p1     <= w_imm_p0;
      r_rd_p1      <= w_rd_p0;
      r_illegal_p1 <= 1'b0;
    end else if (w_accept_p0) begin
      // Unsupported opcode: drop it, issue a bubble, raise the flag once.
      r_inst_p1    <= NOP_INST;
      r_op1_p1     <= '0;
      r_op2_p1     <= '0;
      r_rd_p1      <= '0;
      r_illegal_p1 <= 1'b1;
    end else begin
      r_inst_p1    <= NOP_INST;
      r_op1_p1     <= '0;
      r_op2_p1     <= '0;
      r_rd_p1      <= '0;
      r_illegal_p1 <= 1'b0;
    end
  end

  assign bus.inst_o      = r_inst_p1;
  assign bus.op1_o       = r_op1_p1;
  assign bus.op2_o       = r_op2_p1;
  assign bus.reg_waddr_o = r_rd_p1;
  assign bus.illegal_o   = r_illegal_p1;

endmodule

// File: tb/tb_id.sv
module tb_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  id_if u_if ();

  id #(
    .NOP_INST   (NOP),
    .CLEAR_REGS (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_out;
  logic [31:0] m_regs [32];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input logic [4:0] a, input logic [31:0] exp, input string tag);
    u_if.dbg_raddr_i = a;
    #1;
    chk(tag, u_if.dbg_rdata_o, exp);
  endtask

  // Drive one cycle, predict the registered result, push it, clock, pop, compare.
  task automatic step(input logic v, input logic [31:0] ins, input logic h,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input string tag);
    exp_t        e;
    exp_t        got;
    logic [4:0]  rs1;
    logic [31:0] op1;
    u_if.inst_valid_i = v;
    u_if.inst_i       = ins;
    u_if.hold_i       = h;
    u_if.wb_we_i      = we;
    u_if.wb_waddr_i   = wa;
    u_if.wb_wdata_i   = wd;
    #1;
    chk({tag, ".ready"}, {31'b0, u_if.inst_ready_o}, {31'b0, ~h});

    rs1 = ins[19:15];
    if (rs1 == 5'd0)                   op1 = 32'h0;
    else if (we && wa == rs1)          op1 = wd;
    else                               op1 = m_regs[rs1];

    e     = m_out;
    e.ill = 1'b0;
    if (rst) begin
      e = '{NOP, 32'h0, 32'h0, 5'd0, 1'b0};
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (!h) begin
      if (v && ins[6:0] == 7'b0010011)
        e = '{ins, op1, {{20{ins[31]}}, ins[31:20]}, ins[11:7], 1'b0};
      else if (v)
        e = '{NOP, 32'h0, 32'h0, 5'd0, 1'b1};
      else
        e = '{NOP, 32'h0, 32'h0, 5'd0, 1'b0};
    end
    if (!rst && we && wa != 5'd0) m_regs[wa] = wd;
    m_out = e;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".inst"}, u_if.inst_o, got.inst);
    chk({tag, ".op1"},  u_if.op1_o,  got.op1);
    chk({tag, ".op2"},  u_if.op2_o,  got.op2);
    chk({tag, ".rd"},   {27'b0, u_if.reg_waddr_o}, {27'b0, got.rd});
    chk({tag, ".ill"},  {31'b0, u_if.illegal_o},   {31'b0, got.ill});
  endtask

  initial begin
    u_if.inst_valid_i = 1'b0;
    u_if.inst_i       = '0;
    u_if.hold_i       = 1'b0;
    u_if.wb_we_i      = 1'b0;
    u_if.wb_waddr_i   = '0;
    u_if.wb_wdata_i   = '0;
    u_if.dbg_raddr_i  = '0;
    m_out = '{NOP, 32'h0, 32'h0, 5'd0, 1'b0};
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    // Reset with an instruction offered: not accepted, bubble issued.
    rst = 1'b1;
    step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0, "rst_a");
    step(1'b1, 32'h0050_0093, 1'b0, 1'b1, 5'd4, 32'h1234, "rst_b");
    rst = 1'b0;

    // ADDI x1,x0,5 on the first edge after reset.
    step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0, "addi_x1");
    chk("addi_x1.imm_const", u_if.op2_o, 32'h5);

    // ADDI x2,x1,-1 with same-cycle writeback x1=5 (bypass).
    step(1'b1, 32'hFFF0_8113, 1'b0, 1'b1, 5'd1, 32'h5, "bypass");
    chk("bypass.op1_const", u_if.op1_o, 32'h5);
    chk("bypass.op2_const", u_if.op2_o, 32'hFFFF_FFFF);
    dbg(5'd1, 32'h5, "dbg_x1_5");

    // R-type: dropped, one-cycle illegal pulse, then idle bubble.
    step(1'b1, 32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'h0, "rtype");
    chk("rtype.ill_const", {31'b0, u_if.illegal_o}, 32'h1);
    step(1'b0, 32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'h0, "idle");

    // ADDI x7,x1,2 then hold three cycles while ADDI x6,x3,1 waits.
    step(1'b1, 32'h0020_8393, 1'b0, 1'b0, 5'd0, 32'h0, "pre_hold");
    step(1'b1, 32'h0011_8313, 1'b1, 1'b1, 5'd3, 32'h7,   "hold1");
    step(1'b1, 32'h0011_8313, 1'b1, 1'b1, 5'd1, 32'd100, "hold2");
    step(1'b1, 32'h0011_8313, 1'b1, 1'b0, 5'd0, 32'h0,   "hold3");
    chk("hold.op1_frozen", u_if.op1_o, 32'h5);
    dbg(5'd3, 32'h7, "dbg_x3_7");
    step(1'b1, 32'h0011_8313, 1'b0, 1'b0, 5'd0, 32'h0, "release");
    chk("release.op1_const", u_if.op1_o, 32'h7);
    dbg(5'd1, 32'd100, "dbg_x1_100");

    // Writes to x0 are ignored and never forwarded.
    step(1'b1, 32'h0030_0413, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, "x0_same");
    step(1'b1, 32'hFFE0_0493, 1'b0, 1'b0, 5'd0, 32'h0, "x0_next");
    dbg(5'd0, 32'h0, "dbg_x0");

    // XORI x10,x1,0x7FF: funct3 passes through, positive max immediate.
    step(1'b1, 32'h7FF0_C513, 1'b0, 1'b0, 5'd0, 32'h0, "xori");

    // Mid-stream reset with x5=9 and an illegal pulse pending.
    step(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h9, "wr_x5");
    dbg(5'd5, 32'h9, "dbg_x5_9");
    step(1'b1, 32'h0000_0033, 1'b0, 1'b0, 5'd0, 32'h0, "pre_rst_ill");
    rst = 1'b1;
    step(1'b1, 32'h0050_0093, 1'b1, 1'b1, 5'd6, 32'h55, "mid_rst");
    rst = 1'b0;
    dbg(5'd5, 32'h0, "dbg_x5_cleared");
    dbg(5'd1, 32'h0, "dbg_x1_cleared");
    dbg(5'd6, 32'h0, "dbg_x6_blocked");

    // First edge after reset accepts normally; x1 now reads 0.
    step(1'b1, 32'h0020_8393, 1'b0, 1'b0, 5'd0, 32'h0, "post_rst");
    chk("post_rst.op1_const", u_if.op1_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
